seven_seg_scan_capture: RTL

Receive-side counterpart of the multiplexed 7-segment scan bus (seg_out/seg_select) used by the chess-clock display path. It samples the time-multiplexed segment and one-hot digit-select lines and debounces each scan slot. It rebuilds the eight per-digit 7-bit segment words and tracks frame ordering. It is used as a display-loopback monitor in the design and as the scoreboard front end in the display testbenches.

---
 rtl/seven_seg_scan_capture_pkg.sv | 40 ++++
 rtl/seven_seg_stable_filter.sv | 70 +++++++
 rtl/seven_seg_scan_capture.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_capture_pkg
// Purpose : Shared display definitions for the 7-segment scan capture path:
//           bus widths, digit count, FSM state type and select-decoding
//           helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seven_seg_scan_capture_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int SEL_W      = 8;
  localparam int IDX_W      = 3;
  localparam int CUR_W      = SEL_W + SEG_W;

  // Frame-ordering state: IDLE waits for slot 1, SCAN tracks the expected slot.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // True when exactly one select line is active.
  function automatic logic is_onehot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - SEL_W'(1))) == '0);
  endfunction

  // Index of the active select line; only meaningful for one-hot inputs.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [SEL_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage : seven_seg_scan_capture_pkg
`default_nettype wire

// File: rtl/seven_seg_stable_filter.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_stable_filter
// Purpose : Debounces one scan slot of the multiplexed 7-segment bus. A slot
//           is accepted once {sel,seg} has been seen unchanged on STABLE_CNT
//           consecutive CE samples; it is accepted once only.
// Ports   : CLK      - system clock
//           CLR      - synchronous active-high reset
//           CE       - sample enable
//           cur      - current sample {sel_in, seg_in}
//           accept   - strobe, valid one-hot slot reached STABLE_CNT samples
//           sel_err  - strobe, a new sample carries a multi-hot select
//           acc_idx  - index of the accepted digit slot
//           acc_seg  - segment pattern of the accepted slot
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_stable_filter
  import seven_seg_scan_capture_pkg::*;
#(
  parameter int STABLE_CNT = 4   // legal range 2..15
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CE,
  input  logic [CUR_W-1:0] cur,
  output logic             accept,
  output logic             sel_err,
  output logic [IDX_W-1:0] acc_idx,
  output logic [SEG_W-1:0] acc_seg
);

  localparam logic [3:0] c_cnt_max = 4'(STABLE_CNT);
  localparam logic [3:0] c_cnt_pre = 4'(STABLE_CNT - 1);

  logic [CUR_W-1:0] r_s_q;
  logic [3:0]       r_cnt;

  logic             w_changed;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_onehot;

  assign w_sel        = cur[CUR_W-1:SEG_W];
  assign w_changed    = (cur != r_s_q);
  assign w_sel_onehot = is_onehot(w_sel);

  // The accept fires on the edge where the count reaches STABLE_CNT, so the
  // downstream registers capture on that same edge. Saturation at
  // STABLE_CNT guarantees a single accept per stable slot. Blank (all-zero)
  // and multi-hot selects fail the one-hot test and are never accepted.
  assign accept  = !CLR && CE && !w_changed && (r_cnt == c_cnt_pre) && w_sel_onehot;
  assign sel_err = !CLR && CE && w_changed && (w_sel != '0) && !w_sel_onehot;
  assign acc_idx = onehot_to_idx(w_sel);
  assign acc_seg = cur[SEG_W-1:0];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_s_q <= '0;
      r_cnt <= '0;
    end else if (CE) begin
      if (w_changed) begin
        r_s_q <= cur;
        r_cnt <= 4'd1;
      end else if (r_cnt < c_cnt_max) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule : seven_seg_stable_filter
`default_nettype wire

// File: rtl/seven_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_capture
// Purpose : Receive-side monitor of the multiplexed 7-segment scan bus.
//           Rebuilds the eight per-digit segment words from debounced scan
//           slots and checks that slots arrive in order 1..8.
// Ports   : CLK, CLR        - clock, synchronous active-high reset
//           CE              - sample enable (scan driver strobe)
//           seg_in, sel_in  - multiplexed segment pattern / one-hot select
//           digit1..digit8  - captured segment word per digit
//           digit_valid     - bit k set once digit k+1 has been captured
//           frame_done      - pulse, slots 1..8 accepted in order
//           seq_err         - pulse, out-of-order slot accepted
//           sel_err         - pulse, new multi-hot select sampled
//           frame_cnt       - completed frame count (wrapping)
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_scan_capture
  import seven_seg_scan_capture_pkg::*;
#(
  parameter int STABLE_CNT = 4,  // legal range 2..15
  parameter int FRAME_W    = 8
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic [SEG_W-1:0]   seg_in,
  input  logic [SEL_W-1:0]   sel_in,
  output logic [SEG_W-1:0]   digit1,
  output logic [SEG_W-1:0]   digit2,
  output logic [SEG_W-1:0]   digit3,
  output logic [SEG_W-1:0]   digit4,
  output logic [SEG_W-1:0]   digit5,
  output logic [SEG_W-1:0]   digit6,
  output logic [SEG_W-1:0]   digit7,
  output logic [SEG_W-1:0]   digit8,
  output logic [NUM_DIGITS-1:0] digit_valid,
  output logic               frame_done,
  output logic               seq_err,
  output logic               sel_err,
  output logic [FRAME_W-1:0] frame_cnt
);

  logic             w_accept;
  logic             w_sel_err;
  logic [IDX_W-1:0] w_idx;
  logic [SEG_W-1:0] w_seg;

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_exp;
  logic [IDX_W-1:0] w_exp_nxt;
  logic [FRAME_W-1:0] w_frame_cnt_nxt;
  logic             w_frame_done_nxt;
  logic             w_seq_err_nxt;

  logic [SEG_W-1:0] r_digit [NUM_DIGITS];

  seven_seg_stable_filter #(
    .STABLE_CNT (STABLE_CNT)
  ) u_filter (
    .CLK     (CLK),
    .CLR     (CLR),
    .CE      (CE),
    .cur     ({sel_in, seg_in}),
    .accept  (w_accept),
    .sel_err (w_sel_err),
    .acc_idx (w_idx),
    .acc_seg (w_seg)
  );

  // Digit capture runs independently of frame ordering: any accepted slot
  // refreshes its digit, even when it breaks the sequence.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_digit[k] <= '0;
      end
      digit_valid <= '0;
    end else if (w_accept) begin
      r_digit[w_idx]     <= w_seg;
      digit_valid[w_idx] <= 1'b1;
    end
  end

  assign digit1 = r_digit[0];
  assign digit2 = r_digit[1];
  assign digit3 = r_digit[2];
  assign digit4 = r_digit[3];
  assign digit5 = r_digit[4];
  assign digit6 = r_digit[5];
  assign digit7 = r_digit[6];
  assign digit8 = r_digit[7];

  // Frame-ordering FSM. After a completed frame exp wraps to 0 while staying
  // in SCAN, so back-to-back frames need no re-sync. A stray slot 1 during
  // SCAN re-syncs in place; any other stray slot drops back to IDLE.
  always_comb begin
    w_state_nxt      = r_state;
    w_exp_nxt        = r_exp;
    w_frame_cnt_nxt  = frame_cnt;
    w_frame_done_nxt = 1'b0;
    w_seq_err_nxt    = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_idx == '0) begin
            w_state_nxt = ST_SCAN;
            w_exp_nxt   = IDX_W'(1);
          end
        end
        ST_SCAN: begin
          if (w_idx == r_exp) begin
            if (r_exp == IDX_W'(NUM_DIGITS - 1)) begin
              w_frame_done_nxt = 1'b1;
              w_frame_cnt_nxt  = frame_cnt + FRAME_W'(1);
              w_exp_nxt        = '0;
            end else begin
              w_exp_nxt = r_exp + IDX_W'(1);
            end
          end else begin
            w_seq_err_nxt = 1'b1;
            if (w_idx == '0) begin
              w_exp_nxt = IDX_W'(1);
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state    <= ST_IDLE;
      r_exp      <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_exp      <= w_exp_nxt;
      frame_cnt  <= w_frame_cnt_nxt;
      frame_done <= w_frame_done_nxt;
      seq_err    <= w_seq_err_nxt;
      sel_err    <= w_sel_err;
    end
  end

endmodule : seven_seg_scan_capture
`default_nettype wire
